spi_slave_fsm: RTL

- Serial front end of the SPI slave wrapper, directly upstream of the single-port RAM.
- Deserialises MOSI into (DATA_WIDTH+2)-bit command/address/data words and presents each word with a one-cycle rx_valid strobe.
- Captures the RAM's read-data response (tx_data/tx_valid) and serialises it MSB-first on MISO.
- Runs on the system clock; SS_n and MOSI are already synchronous to clk.

---
 rtl/spi_slave_fsm.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_fsm.sv
// SPI slave serial front end: deserialises MOSI command/address/data words for the
// RAM and serialises the RAM read data back out on MISO, MSB first.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   IDLE      | deselected, waiting for SS_n low
//   CHK_CMD   | sampling the command MSB to choose the write or read path
//   WRITE     | receiving a write-address / write-data word
//   READ_ADD  | receiving a read-address word; completion arms rd_addr_seen
//   READ_DATA | receiving a read-data request, then shifting tx_data out on MISO
module spi_slave_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int RW  = DATA_WIDTH + 2;
  localparam int CW  = $clog2(RW);
  localparam int TCW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         rx_shift_q, rx_shift_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic                  rx_done_q, rx_done_d;
  logic [RW-1:0]         rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rd_addr_seen_q, rd_addr_seen_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [TCW-1:0]        tx_cnt_q, tx_cnt_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  tx_done_q, tx_done_d;
  logic                  miso_q, miso_d;

  always_comb begin
    state_d        = state_q;
    rx_shift_d     = rx_shift_q;
    rx_cnt_d       = rx_cnt_q;
    rx_done_d      = rx_done_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;
    miso_d         = 1'b0;

    // Deselect aborts everything except the read-address history.
    if (state_q != IDLE && SS_n) begin
      state_d    = IDLE;
      rx_shift_d = '0;
      rx_cnt_d   = '0;
      rx_done_d  = 1'b0;
      tx_shift_d = '0;
      tx_cnt_d   = '0;
      tx_busy_d  = 1'b0;
      tx_done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!SS_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          rx_shift_d = {{(RW-1){1'b0}}, MOSI};
          rx_cnt_d   = CW'(DATA_WIDTH);
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!rx_done_q) begin
            rx_shift_d = {rx_shift_q[RW-2:0], MOSI};
            if (rx_cnt_q == '0) begin
              rx_done_d  = 1'b1;
              rx_data_d  = {rx_shift_q[RW-2:0], MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
              if (state_q == READ_DATA) rd_addr_seen_d = 1'b0;
            end else begin
              rx_cnt_d = rx_cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // One transmit per read-data frame, only once the request word is complete.
      if (state_q == READ_DATA && rx_done_q) begin
        if (tx_busy_q) begin
          miso_d     = tx_shift_q[DATA_WIDTH-1];
          tx_shift_d = tx_shift_q << 1;
          if (tx_cnt_q == '0) begin
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
          end else begin
            tx_cnt_d = tx_cnt_q - 1'b1;
          end
        end else if (!tx_done_q && tx_valid) begin
          tx_shift_d = tx_data;
          tx_cnt_d   = TCW'(DATA_WIDTH - 1);
          tx_busy_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rx_shift_q     <= '0;
      rx_cnt_q       <= '0;
      rx_done_q      <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_shift_q     <= rx_shift_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_done_q      <= rx_done_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
      miso_q         <= miso_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
